// File: rtl/m_ctrl_if.sv
// Memory and accumulator-operand bus between the m_ctrl sequencer, its
// instruction/data memories and the downstream m_acc adder stage.
interface m_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_re;
    logic [DATA_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic              dmem_re;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_b;

    modport master (
        output imem_addr, imem_re, dmem_addr, dmem_re, dmem_we, dmem_wdata,
               acc_a, acc_b,
        input  imem_rdata, dmem_rdata, acc_q
    );

    modport slave (
        input  imem_addr, imem_re, dmem_addr, dmem_re, dmem_we, dmem_wdata,
               acc_a, acc_b,
        output imem_rdata, dmem_rdata, acc_q
    );
endinterface

// File: rtl/m_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit MPU; steers the m_acc adder
// operands so the accumulator holds except during LDI/ADDI/ADDM updates.
module m_ctrl #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 5,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    m_ctrl_if.master          bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_ADDM = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HLT  = 3'b111;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir_q[DATA_W-1 -: 3];
    assign operand = ir_q[ADDR_W-1:0];

    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = operand;
    assign bus.dmem_wdata = bus.acc_q;
    assign busy   = (state_q == FETCH) || (state_q == DECODE) ||
                    (state_q == EXEC)  || (state_q == MEM);
    assign halted = (state_q == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc      <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc;
        ir_d        = ir_q;
        bus.imem_re = 1'b0;
        bus.dmem_re = 1'b0;
        bus.dmem_we = 1'b0;
        bus.acc_a   = bus.acc_q;
        bus.acc_b   = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
            end
            FETCH: begin
                bus.imem_re = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                ir_d    = bus.imem_rdata;
                pc_d    = pc + ADDR_W'(1);
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                unique case (opcode)
                    OP_NOP: ;
                    OP_LDI: begin
                        bus.acc_a = '0;
                        bus.acc_b = {{(DATA_W-ADDR_W){1'b0}}, operand};
                    end
                    OP_ADDI: begin
                        bus.acc_b = {{(DATA_W-ADDR_W){1'b0}}, operand};
                    end
                    OP_ADDM: begin
                        bus.dmem_re = 1'b1;
                        state_d     = MEM;
                    end
                    OP_STA: bus.dmem_we = 1'b1;
                    OP_JMP: pc_d = operand;
                    OP_JZ: begin
                        if (bus.acc_q == '0) pc_d = operand;
                    end
                    OP_HLT: state_d = HALT;
                    default: ;
                endcase
            end
            MEM: begin
                bus.acc_b = bus.dmem_rdata;
                state_d   = FETCH;
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

endmodule
